time_keeper: RTL and testbench

- Real-time HH:MM:SS counter.
- Sits directly upstream of the alarm block and supplies its current_time input.
- Shares mode and edit_btns with the alarm block. With mode=0 the buttons edit this block's time. With mode=1 this block ignores the buttons and keeps counting, and the alarm block edits its own time.
- Derives a 1 Hz tick from clk with a prescaler and adds auto-repeat for held edit buttons.

---
 rtl/time_keeper.sv | 148 ++++++++++++++
 tb/tb_time_keeper.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// HH:MM:SS real-time counter. A prescaler supplies the 1 Hz tick, and the hour and
// minute buttons edit the time on press and on auto-repeat while held (mode=0 only).
module time_keeper #(
    parameter int TICK_DIV      = 100000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic [1:0]  edit_btns,
    output logic [16:0] current_time,
    output logic        sec_tick
);

    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(REP_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [CW-1:0] DELAY_CNT  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_CNT = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [4:0]            hours_q, hours_d;
    logic [5:0]            mins_q, mins_d;
    logic [5:0]            secs_q, secs_d;
    logic                  sec_tick_q, sec_tick_d;
    logic [1:0]            hist_q;
    logic [1:0]            armed_q, armed_d;
    logic [1:0]            in_rep_q, in_rep_d;
    logic [1:0][CW-1:0]    rep_cnt_q, rep_cnt_d;

    logic [1:0] rise;
    logic [1:0] run;
    logic [1:0] edit_ev;
    logic       tick;
    logic       min_edit;
    logic       hr_edit;
    logic       hr_carry;

    function automatic logic [4:0] inc_hours(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [5:0] inc_sixty(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // A hold only counts towards auto-repeat if it began with a real rising edge,
    // so a button held through reset stays inert until pressed again.
    assign rise     = edit_btns & ~hist_q;
    assign run      = edit_btns & ~{2{mode}} & (armed_q | rise);
    assign tick     = (presc_q == PRESC_LAST);
    assign min_edit = edit_ev[0];
    assign hr_edit  = edit_ev[1];

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        armed_d   = armed_q;
        in_rep_d  = in_rep_q;
        rep_cnt_d = rep_cnt_q;
        edit_ev   = '0;
        for (int b = 0; b < 2; b++) begin
            if (!edit_btns[b]) begin
                armed_d[b] = 1'b0;
            end else if (rise[b]) begin
                armed_d[b] = 1'b1;
            end

            if (!run[b]) begin
                rep_cnt_d[b] = '0;
                in_rep_d[b]  = 1'b0;
            end else if (rep_cnt_q[b] == (in_rep_q[b] ? PERIOD_CNT : DELAY_CNT)) begin
                rep_cnt_d[b] = CNT_ONE;
                in_rep_d[b]  = 1'b1;
                edit_ev[b]   = 1'b1;
            end else begin
                rep_cnt_d[b] = rep_cnt_q[b] + CNT_ONE;
            end

            if (rise[b] && !mode) begin
                edit_ev[b] = 1'b1;
            end
        end
    end

    // A minute edit restarts the second, so it swallows a coincident tick.
    always_comb begin
        presc_d    = presc_q + PRESC_ONE;
        secs_d     = secs_q;
        mins_d     = mins_q;
        hours_d    = hours_q;
        sec_tick_d = 1'b0;
        hr_carry   = 1'b0;

        if (min_edit) begin
            presc_d = '0;
            secs_d  = '0;
            mins_d  = inc_sixty(mins_q);
        end else if (tick) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            secs_d     = inc_sixty(secs_q);
            if (secs_q == 6'd59) begin
                mins_d   = inc_sixty(mins_q);
                hr_carry = (mins_q == 6'd59);
            end
        end

        case ({hr_edit, hr_carry})
            2'b11:          hours_d = inc_hours(inc_hours(hours_q));
            2'b10, 2'b01:   hours_d = inc_hours(hours_q);
            default:        hours_d = hours_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            hours_q    <= '0;
            mins_q     <= '0;
            secs_q     <= '0;
            sec_tick_q <= 1'b0;
            hist_q     <= 2'b11;
            armed_q    <= '0;
            in_rep_q   <= '0;
            rep_cnt_q  <= '0;
        end else begin
            presc_q    <= presc_d;
            hours_q    <= hours_d;
            mins_q     <= mins_d;
            secs_q     <= secs_d;
            sec_tick_q <= sec_tick_d;
            hist_q     <= edit_btns;
            armed_q    <= armed_d;
            in_rep_q   <= in_rep_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign current_time = {hours_q, mins_q, secs_q};
    assign sec_tick     = sec_tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: a seconds-of-day model with per-button hold
// tracking predicts current_time and sec_tick every cycle.
module tb_time_keeper;

    localparam int TD = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        mode      = 1'b0;
    logic [1:0]  edit_btns = 2'b00;
    logic [16:0] current_time;
    logic        sec_tick;

    int total = 0;
    int bad   = 0;

    time_keeper #(
        .TICK_DIV      (TD),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .edit_btns    (edit_btns),
        .current_time (current_time),
        .sec_tick     (sec_tick)
    );

    always #5 clk = ~clk;

    // Reference model: time as seconds-of-day, phase within the second, and for each
    // button whether the current hold is eligible and how long it has been held in mode 0.
    int m_sod;
    int m_phase;
    bit m_tick;
    bit m_prev [2];
    bit m_elig [2];
    int m_run  [2];

    function automatic int m_hours();
        return m_sod / 3600;
    endfunction

    function automatic int m_mins();
        return (m_sod / 60) % 60;
    endfunction

    function automatic int m_secs();
        return m_sod % 60;
    endfunction

    function automatic logic [16:0] exp_time();
        int h, mi, s;
        h  = m_hours();
        mi = m_mins();
        s  = m_secs();
        return {h[4:0], mi[5:0], s[5:0]};
    endfunction

    task automatic model_reset();
        m_sod   = 0;
        m_phase = 0;
        m_tick  = 0;
        for (int b = 0; b < 2; b++) begin
            m_prev[b] = 1;
            m_elig[b] = 0;
            m_run[b]  = 0;
        end
    endtask

    task automatic model_step();
        bit ev [2];
        bit lvl, rise, tk;
        int h, mi, s;
        tk = (m_phase == TD - 1);
        for (int b = 0; b < 2; b++) begin
            lvl  = edit_btns[b];
            rise = lvl && !m_prev[b];
            if (!lvl) m_elig[b] = 0;
            else if (rise) m_elig[b] = 1;
            ev[b] = 0;
            if (!lvl || mode || !m_elig[b]) begin
                m_run[b] = 0;
            end else begin
                if (rise) ev[b] = 1;
                else if (m_run[b] >= RD && (m_run[b] - RD) % RP == 0) ev[b] = 1;
                m_run[b]++;
            end
            m_prev[b] = lvl;
        end

        h  = m_hours();
        mi = m_mins();
        s  = m_secs();
        if (ev[0]) begin
            mi      = (mi + 1) % 60;
            s       = 0;
            m_phase = 0;
            m_tick  = 0;
            if (ev[1]) h = (h + 1) % 24;
        end else begin
            if (tk) begin
                m_sod = (m_sod + 1) % 86400;
                h  = m_hours();
                mi = m_mins();
                s  = m_secs();
            end
            if (ev[1]) h = (h + 1) % 24;
            m_tick  = tk;
            m_phase = tk ? 0 : m_phase + 1;
        end
        m_sod = h * 3600 + mi * 60 + s;
    endtask

    task automatic step(input logic md, input logic [1:0] btns, input logic rst);
        @(negedge clk);
        mode      = md;
        edit_btns = btns;
        reset     = rst;
        if (!rst) model_reset();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        #1;
    endtask

    task automatic press(input logic [1:0] btns);
        step(1'b0, btns, 1'b1);
        step(1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 1'b0);
            total++;
            if (current_time !== 17'd0 || sec_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: time=%h sec_tick=%b expected time=0 sec_tick=0", current_time, sec_tick);
            end
        end
        for (int i = 0; i < 14; i++) begin
            step(1'b0, (i >= 10) ? 2'b01 : 2'b00, 1'b1);
            total++;
            if (current_time !== exp_time() || sec_tick !== m_tick) begin
                bad++;
                $display("FAIL reset_count cyc%0d: time=%h sec_tick=%b expected time=%h sec_tick=%b",
                         i, current_time, sec_tick, exp_time(), m_tick);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (current_time !== 17'd0 || sec_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: time=%h sec_tick=%b expected time=0 sec_tick=0", current_time, sec_tick);
        end
        step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b01, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 2'b01, 1'b1);
            total++;
            if (current_time !== exp_time() || sec_tick !== m_tick || current_time[11:6] !== 6'd0) begin
                bad++;
                $display("FAIL reset_held_btn cyc%0d: time=%h sec_tick=%b expected time=%h sec_tick=%b minutes=0",
                         i, current_time, sec_tick, exp_time(), m_tick);
            end
        end
        step(1'b0, 2'b00, 1'b1);
        step(1'b0, 2'b01, 1'b1);
        total++;
        if (current_time[11:6] !== 6'd1 || current_time !== exp_time()) begin
            bad++;
            $display("FAIL reset_repress: time=%h expected time=%h minutes=1", current_time, exp_time());
        end
        step(1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_rollover();
        int n;
        int tick_cnt;
        bit found;
        n = (59 - m_mins() + 60) % 60;
        for (int i = 0; i < n; i++) press(2'b01);
        n = (23 - m_hours() + 24) % 24;
        for (int i = 0; i < n; i++) press(2'b10);
        total++;
        if (current_time !== exp_time() || current_time[16:6] !== {5'd23, 6'd59}) begin
            bad++;
            $display("FAIL rollover_preload: time=%h expected time=%h at 23:59", current_time, exp_time());
        end
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 2'b00, 1'b1);
            if (m_sod == 86398 && m_tick) found = 1;
        end
        total++;
        if (!found || current_time !== exp_time()) begin
            bad++;
            $display("FAIL rollover_reach: time=%h expected time=%h reached=%0d", current_time, exp_time(), found);
        end
        tick_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 2'b00, 1'b1);
            if (sec_tick === 1'b1) tick_cnt++;
            total++;
            if (current_time !== exp_time() || sec_tick !== (i == 4 || i == 8)) begin
                bad++;
                $display("FAIL rollover_run cyc%0d: time=%h sec_tick=%b expected time=%h", i, current_time, sec_tick, exp_time());
            end
            if (i == 4) begin
                total++;
                if (current_time !== {5'd23, 6'd59, 6'd59}) begin
                    bad++;
                    $display("FAIL rollover_2359: time=%h expected time=%h", current_time, {5'd23, 6'd59, 6'd59});
                end
            end
        end
        total++;
        if (current_time !== 17'd0 || tick_cnt != 2) begin
            bad++;
            $display("FAIL rollover_wrap: time=%h ticks=%0d expected time=0 ticks=2", current_time, tick_cnt);
        end
    endtask

    task automatic test_hours();
        int n;
        n = (21 - m_hours() + 24) % 24;
        for (int i = 0; i < n; i++) press(2'b10);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'b10, 1'b1);
            total++;
            if (current_time !== exp_time() || current_time[16:12] !== 5'((21 + i + 1) % 24)) begin
                bad++;
                $display("FAIL hours_press%0d: time=%h expected time=%h hours=%0d",
                         i, current_time, exp_time(), (21 + i + 1) % 24);
            end
            step(1'b0, 2'b00, 1'b1);
        end
    endtask

    task automatic test_min_repeat();
        int n, cnt;
        bit is_edit;
        n = (5 - m_mins() + 60) % 60;
        for (int i = 0; i < n; i++) press(2'b01);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 2'b01, 1'b1);
            cnt     = 1 + ((k >= RD) ? (k - RD) / RP + 1 : 0);
            is_edit = (k == 0) || (k >= RD && (k - RD) % RP == 0);
            total++;
            if (current_time !== exp_time() || sec_tick !== m_tick ||
                current_time[11:6] !== 6'(5 + cnt) || (is_edit && current_time[5:0] !== 6'd0)) begin
                bad++;
                $display("FAIL min_repeat k%0d: time=%h sec_tick=%b expected time=%h minutes=%0d",
                         k, current_time, sec_tick, exp_time(), 5 + cnt);
            end
        end
        step(1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_min_tick();
        bit found;
        int old_min;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b0, 2'b00, 1'b1);
            if (m_secs() == 30 && m_phase == TD - 1) found = 1;
        end
        old_min = m_mins();
        step(1'b0, 2'b01, 1'b1);
        total++;
        if (!found || current_time[5:0] !== 6'd0 || sec_tick !== 1'b0 ||
            current_time[11:6] !== 6'((old_min + 1) % 60) || current_time !== exp_time()) begin
            bad++;
            $display("FAIL min_tick_edit: time=%h sec_tick=%b expected time=%h sec_tick=0 reached=%0d",
                     current_time, sec_tick, exp_time(), found);
        end
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 2'b00, 1'b1);
            total++;
            if (sec_tick !== (j == 4) || current_time !== exp_time()) begin
                bad++;
                $display("FAIL min_tick_next j%0d: time=%h sec_tick=%b expected time=%h sec_tick=%b",
                         j, current_time, sec_tick, exp_time(), j == 4);
            end
        end
    endtask

    task automatic test_mode();
        int saved_min, saved_hr, n;
        logic [1:0] b;
        press(2'b01);
        saved_min = m_mins();
        saved_hr  = m_hours();
        for (int i = 0; i < 30; i++) begin
            b = (i >= 28) ? 2'b11 : 2'($urandom_range(3));
            step(1'b1, b, 1'b1);
            total++;
            if (current_time !== exp_time() || sec_tick !== m_tick || current_time[11:6] !== 6'(saved_min)) begin
                bad++;
                $display("FAIL mode1_ignore cyc%0d: time=%h sec_tick=%b expected time=%h minutes=%0d",
                         i, current_time, sec_tick, exp_time(), saved_min);
            end
        end
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 2'b11, 1'b1);
            n = (j >= RD) ? (j - RD) / RP + 1 : 0;
            total++;
            if (current_time !== exp_time() || current_time[11:6] !== 6'((saved_min + n) % 60) ||
                current_time[16:12] !== 5'((saved_hr + n) % 24)) begin
                bad++;
                $display("FAIL mode_switch j%0d: time=%h expected time=%h edits=%0d", j, current_time, exp_time(), n);
            end
        end
        step(1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_both();
        int h0, m0;
        h0 = m_hours();
        m0 = m_mins();
        step(1'b0, 2'b11, 1'b1);
        total++;
        if (current_time !== exp_time() || current_time[16:12] !== 5'((h0 + 1) % 24) ||
            current_time[11:6] !== 6'((m0 + 1) % 60) || current_time[5:0] !== 6'd0) begin
            bad++;
            $display("FAIL both_btns: time=%h expected time=%h", current_time, exp_time());
        end
        step(1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_random();
        logic md;
        logic [1:0] b;
        md = 1'b0;
        b  = 2'b00;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(15) == 0) md = ~md;
            if ($urandom_range(7) == 0) b[0] = ~b[0];
            if ($urandom_range(7) == 0) b[1] = ~b[1];
            step(md, b, 1'b1);
            total++;
            if (current_time !== exp_time() || sec_tick !== m_tick) begin
                bad++;
                $display("FAIL random cyc%0d: time=%h sec_tick=%b expected time=%h sec_tick=%b",
                         i, current_time, sec_tick, exp_time(), m_tick);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rollover();
        test_hours();
        test_min_repeat();
        test_min_tick();
        test_mode();
        test_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
